// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch queue: FSM states, the NOP
// shown on instrD after reset, and the {instr, pc} FIFO entry.
package fetch_pkg;

    typedef enum logic {
        S_BOOT = 1'b0,
        S_RUN  = 1'b1
    } fq_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fq_entry_t;

endpackage

// File: rtl/fq_fifo.sv
// Power-of-two FIFO of fetched {instr, pc} entries with a flush input.
// The head entry is read straight from the storage registers.
module fq_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic                       clear_i,
    input  fq_entry_t                  wdata_i,
    output fq_entry_t                  rdata_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    fq_entry_t     mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q;
    logic [AW-1:0] wr_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push;
    logic          do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(push_i && !clear_i && full_o && !do_pop));

endmodule

// File: rtl/fetch_queue.sv
// Fetch stage: pipelined in-order imem requests, response buffering, redirect flush.
// Define FETCH_QUEUE_STATS_EN to add the stall/empty/flush statistics ports.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter int          MAX_OUT  = 2,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    input  logic        StallD,
    output logic        validD,
    output logic [31:0] instrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D
`ifdef FETCH_QUEUE_STATS_EN
    ,
    output logic [31:0] stat_stall_cyc,
    output logic [31:0] stat_empty_cyc,
    output logic [15:0] stat_flushes
`endif
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(MAX_OUT + 1);
    localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

    fq_state_e     state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [IW-1:0] inflight_q, inflight_d;
    logic [IW-1:0] drop_cnt_q, drop_cnt_d;
    logic [31:0]   addr_q [MAX_OUT];
    logic [PW-1:0] addr_wr_q;
    logic [PW-1:0] addr_rd_q;
    fq_entry_t     last_q;
    logic [31:0]   last_plus4_q;

    logic          credit_ok;
    logic          accept;
    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    fq_entry_t     fifo_wdata;
    fq_entry_t     fifo_head;

    // Dropped-but-outstanding requests still hold a credit, so a response can never find the FIFO full.
    assign credit_ok = ((int'(fifo_count) + int'(inflight_q)) < DEPTH) && (int'(inflight_q) < MAX_OUT);

    always_comb begin
        state_d  = state_q;
        imem_req = 1'b0;
        case (state_q)
            S_BOOT:  state_d  = S_RUN;
            S_RUN:   imem_req = credit_ok && !PCSrcE;
            default: state_d  = S_BOOT;
        endcase
    end

    assign imem_addr = fetch_pc_q;
    assign accept    = imem_req && imem_ready;

    always_comb begin
        inflight_d = inflight_q + IW'(accept) - IW'(imem_rvalid);
        drop_cnt_d = drop_cnt_q;
        fetch_pc_d = fetch_pc_q;
        if (PCSrcE) begin
            drop_cnt_d = inflight_d;
            fetch_pc_d = PCTargetE & 32'hFFFF_FFFC;
        end else begin
            if (imem_rvalid && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - 1'b1;
            if (accept) fetch_pc_d = fetch_pc_q + 32'd4;
        end
    end

    assign fifo_push  = imem_rvalid && (drop_cnt_q == '0) && !PCSrcE;
    assign fifo_pop   = validD && !StallD && !PCSrcE;
    assign fifo_wdata = '{instr: imem_rdata, pc: addr_q[addr_rd_q]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_BOOT;
            fetch_pc_q   <= RESET_PC;
            inflight_q   <= '0;
            drop_cnt_q   <= '0;
            addr_wr_q    <= '0;
            addr_rd_q    <= '0;
            last_q       <= '{instr: NOP_INSTR, pc: 32'h0};
            last_plus4_q <= 32'h0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            inflight_q <= inflight_d;
            drop_cnt_q <= drop_cnt_d;
            // PC FIFO tracks every outstanding request, dropped or not, so it stays aligned with responses.
            if (accept)
                addr_wr_q <= (addr_wr_q == PW'(MAX_OUT - 1)) ? '0 : addr_wr_q + 1'b1;
            if (imem_rvalid)
                addr_rd_q <= (addr_rd_q == PW'(MAX_OUT - 1)) ? '0 : addr_rd_q + 1'b1;
            if (!fifo_empty) begin
                last_q       <= fifo_head;
                last_plus4_q <= fifo_head.pc + 32'd4;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) addr_q[addr_wr_q] <= imem_addr;
    end

    fq_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .push_i (fifo_push),
        .pop_i  (fifo_pop),
        .clear_i(PCSrcE),
        .wdata_i(fifo_wdata),
        .rdata_o(fifo_head),
        .count_o(fifo_count),
        .full_o (fifo_full),
        .empty_o(fifo_empty)
    );

    // When empty the outputs hold the last head that was presented.
    assign validD   = !fifo_empty;
    assign instrD   = fifo_empty ? last_q.instr  : fifo_head.instr;
    assign PCD      = fifo_empty ? last_q.pc     : fifo_head.pc;
    assign PCPlus4D = fifo_empty ? last_plus4_q  : fifo_head.pc + 32'd4;

`ifdef FETCH_QUEUE_STATS_EN
    logic [31:0] stall_cyc_q;
    logic [31:0] empty_cyc_q;
    logic [15:0] flushes_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cyc_q <= '0;
            empty_cyc_q <= '0;
            flushes_q   <= '0;
        end else begin
            if (validD && StallD && (stall_cyc_q != '1))
                stall_cyc_q <= stall_cyc_q + 1'b1;
            if ((state_q == S_RUN) && !validD && (empty_cyc_q != '1))
                empty_cyc_q <= empty_cyc_q + 1'b1;
            if (PCSrcE && (flushes_q != '1))
                flushes_q <= flushes_q + 1'b1;
        end
    end

    assign stat_stall_cyc = stall_cyc_q;
    assign stat_empty_cyc = empty_cyc_q;
    assign stat_flushes   = flushes_q;
`endif

    a_inflight_bound: assert property (@(posedge clk) disable iff (reset)
        int'(inflight_q) <= MAX_OUT);
    a_no_stray_resp: assert property (@(posedge clk) disable iff (reset)
        !(imem_rvalid && (inflight_q == '0)));
    a_no_full_push: assert property (@(posedge clk) disable iff (reset)
        !(fifo_push && fifo_full && !fifo_pop));

endmodule
